// File: rtl/dice_result_tracker.sv
// dice_result_tracker
//   Captures the final dice face when the roll button is released. Each capture
//   is offered downstream over a valid/ready handshake. The block also keeps
//   per-face and total roll statistics, flags doubles and drives a 7-segment
//   display of the last legal face.
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   button, throw     roll button and dice face (legal 1..6)
//   result_ready      downstream accepts the pending result this cycle
//   result_valid      result/double are valid and held stable
//   result, double    captured face and "same as previous legal face" flag
//   overrun           sticky: a capture was dropped while a result was pending
//   seg               active-low {g,f,e,d,c,b,a} pattern of the last legal face
//   count_sel         face whose counter is shown on count_out
//   count_out         roll count of face count_sel (0 for sel 0 or 7)
//   total, err_cnt    legal capture count and illegal capture count
module dice_result_tracker #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TOT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic [2:0]       throw,
   input  logic             result_ready,
   output logic             result_valid,
   output logic [2:0]       result,
   output logic             double,
   output logic             overrun,
   output logic [6:0]       seg,
   input  logic [2:0]       count_sel,
   output logic [CNT_W-1:0] count_out,
   output logic [TOT_W-1:0] total,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned NUM_FACES = 6;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_nxt;
   logic             button_d;
   logic [2:0]       prev_face;
   logic [CNT_W-1:0] face_cnt [NUM_FACES];

   logic             release_c;
   logic             legal_c;
   logic             illegal_c;
   logic             xfer_c;
   logic             load_c;
   logic             drop_c;
   logic [2:0]       face_idx_c;
   logic [6:0]       seg_c;

   // The dice freezes on the same edge the button is seen released
   assign release_c  = button_d & ~button;
   assign legal_c    = release_c & (throw != 3'd0) & (throw != 3'd7);
   assign illegal_c  = release_c & ((throw == 3'd0) | (throw == 3'd7));
   assign xfer_c     = (state == FULL) & result_ready;
   assign face_idx_c = 3'(throw - 3'd1);

   // Face to active-low segment pattern
   always_comb begin
      seg_c = 7'h7F;
      case (throw)
         3'd1:    seg_c = 7'h79;
         3'd2:    seg_c = 7'h24;
         3'd3:    seg_c = 7'h30;
         3'd4:    seg_c = 7'h19;
         3'd5:    seg_c = 7'h12;
         3'd6:    seg_c = 7'h02;
         default: seg_c = 7'h7F;
      endcase
   end

   // Handshake next-state: a capture while full is kept only if the old result leaves
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      drop_c    = 1'b0;
      case (state)
         EMPTY: begin
            if (legal_c) begin
               load_c    = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (xfer_c) begin
               if (legal_c) load_c = 1'b1;
               else         state_nxt = EMPTY;
            end else if (legal_c) begin
               drop_c = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Result, statistics and display registers
   always_ff @(posedge clk) begin
      if (rst) begin
         button_d     <= 1'b0;
         result_valid <= 1'b0;
         result       <= 3'd0;
         double       <= 1'b0;
         overrun      <= 1'b0;
         seg          <= 7'h7F;
         prev_face    <= 3'd0;
         total        <= '0;
         err_cnt      <= '0;
         for (int i = 0; i < NUM_FACES; i++) face_cnt[i] <= '0;
      end else begin
         button_d     <= button;
         result_valid <= (state_nxt == FULL);
         if (load_c) begin
            result <= throw;
            double <= (throw == prev_face);
         end
         if (drop_c) overrun <= 1'b1;
         if (legal_c) begin
            prev_face <= throw;
            seg       <= seg_c;
            if (total != {TOT_W{1'b1}}) total <= total + TOT_W'(1);
            if (face_cnt[face_idx_c] != {CNT_W{1'b1}})
               face_cnt[face_idx_c] <= face_cnt[face_idx_c] + CNT_W'(1);
         end
         if (illegal_c && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
      end
   end

   // Counter readout; selects 0 and 7 have no counter
   always_comb begin
      count_out = '0;
      if ((count_sel != 3'd0) && (count_sel != 3'd7))
         count_out = face_cnt[3'(count_sel - 3'd1)];
   end

endmodule

// File: tb/tb_dice_result_tracker.sv
// tb_dice_result_tracker
//   Self-checking bench for dice_result_tracker. A reference model tracks the
//   statistics and a queue holds the results the DUT owes downstream.
//   A second instance with narrow counters exercises saturation.
module tb_dice_result_tracker;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned TOT_W = 12;
   localparam int CMAX = (1 << CNT_W) - 1;
   localparam int TMAX = (1 << TOT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             button;
   logic [2:0]       throw;
   logic             result_ready;
   logic [2:0]       count_sel;

   logic             result_valid, double, overrun;
   logic [2:0]       result;
   logic [6:0]       seg;
   logic [CNT_W-1:0] count_out, err_cnt;
   logic [TOT_W-1:0] total;

   logic             result_valid_s, double_s, overrun_s;
   logic [2:0]       result_s;
   logic [6:0]       seg_s;
   logic [1:0]       count_out_s, err_cnt_s;
   logic [2:0]       total_s;

   dice_result_tracker #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
      .clk(clk), .rst(rst), .button(button), .throw(throw),
      .result_ready(result_ready), .result_valid(result_valid),
      .result(result), .double(double), .overrun(overrun), .seg(seg),
      .count_sel(count_sel), .count_out(count_out), .total(total),
      .err_cnt(err_cnt)
   );

   dice_result_tracker #(.CNT_W(2), .TOT_W(3)) dut_s (
      .clk(clk), .rst(rst), .button(button), .throw(throw),
      .result_ready(result_ready), .result_valid(result_valid_s),
      .result(result_s), .double(double_s), .overrun(overrun_s), .seg(seg_s),
      .count_sel(count_sel), .count_out(count_out_s), .total(total_s),
      .err_cnt(err_cnt_s)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] face;
      logic       dbl;
   } exp_t;

   exp_t       q[$];
   int         m_cnt [1:6];
   int         m_total, m_err;
   logic [2:0] m_prev;
   logic       m_ovr;
   logic [6:0] m_seg;
   int         errors = 0;
   int         checks = 0;

   function automatic logic [6:0] seg_of(input logic [2:0] f);
      case (f)
         3'd1: return 7'h79;
         3'd2: return 7'h24;
         3'd3: return 7'h30;
         3'd4: return 7'h19;
         3'd5: return 7'h12;
         3'd6: return 7'h02;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int f = 1; f <= 6; f++) m_cnt[f] = 0;
      m_total = 0;
      m_err   = 0;
      m_prev  = 3'd0;
      m_ovr   = 1'b0;
      m_seg   = 7'h7F;
      q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; button = 1'b0; throw = 3'd0; result_ready = 1'b0; count_sel = 3'd0;
      tick(); tick();
      rst = 1'b0;
      model_reset();
   endtask

   // Compare every observable output of the main instance against the model
   task automatic check_state(input string tag);
      logic exp_v;
      exp_v = (q.size() != 0);
      checks++;
      if (result_valid !== exp_v) begin
         errors++; $display("FAIL %s result_valid got %b exp %b", tag, result_valid, exp_v);
      end
      if (exp_v) begin
         checks++;
         if (result !== q[0].face || double !== q[0].dbl) begin
            errors++;
            $display("FAIL %s result/double got %0d/%b exp %0d/%b", tag, result, double, q[0].face, q[0].dbl);
         end
      end
      checks++;
      if (seg !== m_seg) begin errors++; $display("FAIL %s seg got %h exp %h", tag, seg, m_seg); end
      checks++;
      if (total !== TOT_W'(m_total)) begin errors++; $display("FAIL %s total got %0d exp %0d", tag, total, m_total); end
      checks++;
      if (err_cnt !== CNT_W'(m_err)) begin errors++; $display("FAIL %s err_cnt got %0d exp %0d", tag, err_cnt, m_err); end
      checks++;
      if (overrun !== m_ovr) begin errors++; $display("FAIL %s overrun got %b exp %b", tag, overrun, m_ovr); end
      for (int f = 1; f <= 6; f++) begin
         count_sel = 3'(f);
         #1;
         checks++;
         if (count_out !== CNT_W'(m_cnt[f])) begin
            errors++; $display("FAIL %s count(%0d) got %0d exp %0d", tag, f, count_out, m_cnt[f]);
         end
      end
   endtask

   // Press for a few cycles, release with the given face and ready level
   task automatic roll(input logic [2:0] face, input logic rdy, input string tag);
      logic xfer;
      logic dbl;
      result_ready = 1'b0;
      button = 1'b1;
      repeat (3) begin
         throw = 3'($urandom_range(1, 6));
         tick();
      end
      button = 1'b0; throw = face; result_ready = rdy;
      xfer = (q.size() != 0) && rdy;
      if (xfer) begin
         checks++;
         if (result !== q[0].face) begin
            errors++; $display("FAIL %s transfer result got %0d exp %0d", tag, result, q[0].face);
         end
         void'(q.pop_front());
      end
      tick();
      if (face >= 3'd1 && face <= 3'd6) begin
         dbl    = (face == m_prev);
         m_prev = face;
         m_seg  = seg_of(face);
         if (m_total < TMAX) m_total++;
         if (m_cnt[face] < CMAX) m_cnt[face]++;
         if (q.size() == 0) q.push_back('{face: face, dbl: dbl});
         else               m_ovr = 1'b1;
      end else if (m_err < CMAX) begin
         m_err++;
      end
      result_ready = 1'b0; throw = 3'd0;
      check_state(tag);
   endtask

   // Accept whatever is pending
   task automatic drain(input string tag);
      if (q.size() != 0) begin
         result_ready = 1'b1;
         void'(q.pop_front());
         tick();
         result_ready = 1'b0;
      end
      check_state(tag);
   endtask

   task automatic test_reset();
      rst = 1'b1; button = 1'b1; throw = 3'd5; result_ready = 1'b1; count_sel = 3'd0;
      tick(); tick();
      // Button still high as reset lifts, released on the very next edge
      rst = 1'b0; button = 1'b0;
      model_reset();
      tick();
      result_ready = 1'b0;
      checks++;
      if (result !== 3'd0 || double !== 1'b0) begin
         errors++; $display("FAIL reset result/double got %0d/%b exp 0/0", result, double);
      end
      check_state("reset");
      count_sel = 3'd0; #1;
      checks++;
      if (count_out !== '0) begin errors++; $display("FAIL sel0 count got %0d exp 0", count_out); end
      count_sel = 3'd7; #1;
      checks++;
      if (count_out !== '0) begin errors++; $display("FAIL sel7 count got %0d exp 0", count_out); end
   endtask

   task automatic test_basic();
      roll(3'd4, 1'b1, "basic");
      checks++;
      if (seg !== 7'h19 || total !== TOT_W'(1) || result !== 3'd4) begin
         errors++; $display("FAIL basic_const seg/total/result got %h/%0d/%0d exp 19/1/4", seg, total, result);
      end
      drain("basic_drain");
   endtask

   task automatic test_double();
      roll(3'd2, 1'b1, "double1");
      drain("double1_drain");
      roll(3'd2, 1'b1, "double2");
      checks++;
      if (double !== 1'b1) begin errors++; $display("FAIL double_flag got %b exp 1", double); end
      drain("double2_drain");
   endtask

   task automatic test_overrun();
      roll(3'd5, 1'b0, "ovr1");
      roll(3'd3, 1'b0, "ovr2");
      checks++;
      if (result !== 3'd5 || overrun !== 1'b1 || seg !== 7'h30) begin
         errors++; $display("FAIL ovr_const result/ovr/seg got %0d/%b/%h exp 5/1/30", result, overrun, seg);
      end
      drain("ovr_drain");
   endtask

   task automatic test_illegal();
      roll(3'd7, 1'b0, "illegal7");
      roll(3'd0, 1'b1, "illegal0");
      // Previous legal face was 3; a double proves prev_face survived
      roll(3'd3, 1'b0, "illegal_prev");
      drain("illegal_drain");
   endtask

   task automatic test_back_to_back();
      do_reset();
      roll(3'd1, 1'b0, "b2b_load");
      roll(3'd6, 1'b1, "b2b_swap");
      checks++;
      if (result_valid !== 1'b1 || result !== 3'd6 || overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_const v/result/ovr got %b/%0d/%b exp 1/6/0", result_valid, result, overrun);
      end
      drain("b2b_drain");
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (9) roll(3'd6, 1'b1, "sat_roll");
      count_sel = 3'd6; #1;
      checks++;
      if (count_out_s !== 2'd3) begin errors++; $display("FAIL sat_count6 got %0d exp 3", count_out_s); end
      checks++;
      if (total_s !== 3'd7) begin errors++; $display("FAIL sat_total got %0d exp 7", total_s); end
      checks++;
      if (result_valid_s !== 1'b1 || result_s !== 3'd6 || double_s !== 1'b1) begin
         errors++; $display("FAIL sat_result v/r/d got %b/%0d/%b exp 1/6/1", result_valid_s, result_s, double_s);
      end
      repeat (4) roll(3'd7, 1'b0, "sat_err");
      checks++;
      if (err_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_err got %0d exp 3", err_cnt_s); end
      // Reset in the middle of a press with a result pending
      button = 1'b1; tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      model_reset();
      count_sel = 3'd6; #1;
      checks++;
      if (result_valid !== 1'b0 || result_valid_s !== 1'b0 || count_out !== '0 || count_out_s !== 2'd0 ||
          total !== '0 || err_cnt_s !== 2'd0) begin
         errors++;
         $display("FAIL midreset v/vs/c/cs/t/es got %b/%b/%0d/%0d/%0d/%0d exp all 0",
                  result_valid, result_valid_s, count_out, count_out_s, total, err_cnt_s);
      end
      button = 1'b0; tick();
      check_state("midreset_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         roll(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
         if ($urandom_range(0, 2) == 0) drain("random_drain");
      end
      drain("random_final");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_double();
      test_overrun();
      test_illegal();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
